// File: rtl/fpu_req_ctrl.sv
// fpu_req_ctrl: credit-based request/response front-end for the FPU wrapper.
// Tracks ops through the fixed FPU latency and queues results in issue order.
module fpu_req_ctrl #(
  parameter int C_OP_W  = 32,
  parameter int C_CMD_W = 4,
  parameter int C_RM_W  = 3,
  parameter int C_TAG_W = 4,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic               Clk_CI,
  input  logic               Rst_RBI,
  input  logic               Req_Valid_SI,
  output logic               Req_Ready_SO,
  input  logic [C_OP_W-1:0]  Req_Operand_a_DI,
  input  logic [C_OP_W-1:0]  Req_Operand_b_DI,
  input  logic [C_RM_W-1:0]  Req_RM_SI,
  input  logic [C_CMD_W-1:0] Req_OP_SI,
  input  logic [C_TAG_W-1:0] Req_Tag_DI,
  input  logic               Halt_SI,
  input  logic               Flush_SI,
  output logic [C_OP_W-1:0]  Fpu_Operand_a_DO,
  output logic [C_OP_W-1:0]  Fpu_Operand_b_DO,
  output logic [C_RM_W-1:0]  Fpu_RM_SO,
  output logic [C_CMD_W-1:0] Fpu_OP_SO,
  output logic               Fpu_Enable_SO,
  output logic               Fpu_Stall_SO,
  input  logic [C_OP_W-1:0]  Fpu_Result_DI,
  input  logic [5:0]         Fpu_Flags_SI,
  output logic               Resp_Valid_SO,
  input  logic               Resp_Ready_SI,
  output logic [C_OP_W-1:0]  Resp_Result_DO,
  output logic [5:0]         Resp_Flags_SO,
  output logic [C_TAG_W-1:0] Resp_Tag_DO
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [C_TAG_W-1:0] tag_q [LATENCY];
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [CW-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [C_OP_W-1:0]  mem_res_q [DEPTH];
  logic [5:0]         mem_flg_q [DEPTH];
  logic [C_TAG_W-1:0] mem_tag_q [DEPTH];

  logic [CW:0] used;
  logic        accept;
  logic        push;
  logic        pop;

  assign used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};

  assign Req_Ready_SO = ~Halt_SI & ~Flush_SI
                      & (used < (CW+1)'(DEPTH));

  // reset gate keeps the FPU idle while the tracker is being cleared
  assign accept = Req_Valid_SI & Req_Ready_SO & Rst_RBI;

  assign Fpu_Operand_a_DO = Req_Operand_a_DI;
  assign Fpu_Operand_b_DO = Req_Operand_b_DI;
  assign Fpu_RM_SO        = Req_RM_SI;
  assign Fpu_OP_SO        = Req_OP_SI;
  assign Fpu_Enable_SO    = accept;
  assign Fpu_Stall_SO     = Halt_SI;

  assign push = vld_q[LATENCY-1] & ~Halt_SI & ~Flush_SI;

  assign Resp_Valid_SO  = (fifo_cnt_q != '0);
  assign pop            = Resp_Valid_SO & Resp_Ready_SI & ~Flush_SI;
  assign Resp_Result_DO = mem_res_q[rptr_q];
  assign Resp_Flags_SO  = mem_flg_q[rptr_q];
  assign Resp_Tag_DO    = mem_tag_q[rptr_q];

  // tracking pipe next state: shift when running, hold on halt
  always_comb begin
    vld_d      = vld_q;
    inflight_d = inflight_q;
    if (Flush_SI) begin
      vld_d      = '0;
      inflight_d = '0;
    end else if (!Halt_SI) begin
      vld_d      = (vld_q << 1) | LATENCY'(accept);
      inflight_d = inflight_q + CW'(accept)
                 - CW'(vld_q[LATENCY-1]);
    end
  end

  // response fifo pointer and occupancy next state
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (Flush_SI) begin
      wptr_d     = '0;
      rptr_d     = '0;
      fifo_cnt_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  // control state registers
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      vld_q      <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // tag pipe runs alongside the FPU pipeline
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else if (!Halt_SI) begin
      tag_q[0] <= Req_Tag_DI;
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // response storage, written when the tracked op leaves the FPU
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_res_q[i] <= '0;
        mem_flg_q[i] <= '0;
        mem_tag_q[i] <= '0;
      end
    end else if (push) begin
      mem_res_q[wptr_q] <= Fpu_Result_DI;
      mem_flg_q[wptr_q] <= Fpu_Flags_SI;
      mem_tag_q[wptr_q] <= tag_q[LATENCY-1];
    end
  end

  // credits must make overflow impossible
  a_no_overflow: assert property (
    @(posedge Clk_CI) disable iff (!Rst_RBI)
    !(push && (fifo_cnt_q == CW'(DEPTH)))
  );

endmodule

// File: tb/tb_fpu_req_ctrl.sv
// tb_fpu_req_ctrl: scoreboard bench for fpu_req_ctrl.
// Behavioural FPU model feeds results back with the same latency.
module tb_fpu_req_ctrl;
  localparam int LAT = 2;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_v, req_r;
  logic [31:0] req_a, req_b;
  logic [2:0]  req_rm;
  logic [3:0]  req_op, req_tag;
  logic        halt, flush;
  logic [31:0] f_a, f_b;
  logic [2:0]  f_rm;
  logic [3:0]  f_op;
  logic        f_en, f_stall;
  logic [31:0] f_res;
  logic [5:0]  f_flg;
  logic        rsp_v, rsp_r;
  logic [31:0] rsp_res;
  logic [5:0]  rsp_flg;
  logic [3:0]  rsp_tag;

  typedef struct packed {
    logic [31:0] res;
    logic [5:0]  flg;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  logic [31:0] fr_q [LAT];
  logic [5:0]  ff_q [LAT];

  always #5 clk = ~clk;

  fpu_req_ctrl #(
    .C_OP_W(32), .C_CMD_W(4), .C_RM_W(3), .C_TAG_W(4),
    .LATENCY(LAT), .DEPTH(DEP)
  ) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .Req_Valid_SI(req_v), .Req_Ready_SO(req_r),
    .Req_Operand_a_DI(req_a), .Req_Operand_b_DI(req_b),
    .Req_RM_SI(req_rm), .Req_OP_SI(req_op),
    .Req_Tag_DI(req_tag),
    .Halt_SI(halt), .Flush_SI(flush),
    .Fpu_Operand_a_DO(f_a), .Fpu_Operand_b_DO(f_b),
    .Fpu_RM_SO(f_rm), .Fpu_OP_SO(f_op),
    .Fpu_Enable_SO(f_en), .Fpu_Stall_SO(f_stall),
    .Fpu_Result_DI(f_res), .Fpu_Flags_SI(f_flg),
    .Resp_Valid_SO(rsp_v), .Resp_Ready_SI(rsp_r),
    .Resp_Result_DO(rsp_res), .Resp_Flags_SO(rsp_flg),
    .Resp_Tag_DO(rsp_tag)
  );

  function automatic logic [31:0] op_res(
    input logic [31:0] a, input logic [31:0] b,
    input logic [3:0] op);
    return a ^ {b[15:0], b[31:16]} ^ {28'd0, op};
  endfunction

  function automatic logic [5:0] op_flg(
    input logic [31:0] a, input logic [31:0] b,
    input logic [2:0] rm);
    return a[5:0] ^ b[5:0] ^ {3'b000, rm};
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // FPU model: fixed-latency pipe that freezes on stall
  always @(posedge clk) begin
    if (!f_stall) begin
      fr_q[0] <= f_en ? op_res(f_a, f_b, f_op) : 32'hDEAD_BEEF;
      ff_q[0] <= f_en ? op_flg(f_a, f_b, f_rm) : 6'h3F;
      for (int i = 1; i < LAT; i++) begin
        fr_q[i] <= fr_q[i-1];
        ff_q[i] <= ff_q[i-1];
      end
    end
  end
  assign f_res = fr_q[LAT-1];
  assign f_flg = ff_q[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (rsp_v && rsp_r) begin
        pop_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("sb_underflow", {60'd0, rsp_tag}, 64'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("resp_res", {32'd0, rsp_res}, {32'd0, e.res});
          chk("resp_flg", {58'd0, rsp_flg}, {58'd0, e.flg});
          chk("resp_tag", {60'd0, rsp_tag}, {60'd0, e.tag});
        end
      end
      if (req_v && req_r) begin
        e.res = op_res(req_a, req_b, req_op);
        e.flg = op_flg(req_a, req_b, req_rm);
        e.tag = req_tag;
        sb.push_back(e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] tag,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [3:0] op,
                      input logic [2:0] rm,
                      output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    req_v = 1'b1;
    req_tag = tag;
    req_a = a;
    req_b = b;
    req_op = op;
    req_rm = rm;
    while (!ok && waits < 40) begin
      @(negedge clk);
      if (req_r) ok = 1'b1;
      else waits++;
      @(posedge clk);
      #1;
    end
    req_v = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (rsp_v) break;
    end
  endtask

  int w, tw, n, acc, seen;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_v = 1'b1;
    req_a = 32'h1234_5678;
    req_b = 32'h0;
    req_rm = '0;
    req_op = '0;
    req_tag = '0;
    halt = 1'b0;
    flush = 1'b0;
    rsp_r = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      fr_q[i] = '0;
      ff_q[i] = '0;
    end
    #1;
    chk("rst_valid", {63'd0, rsp_v}, 64'd0);
    chk("rst_res", {32'd0, rsp_res}, 64'd0);
    chk("rst_flg", {58'd0, rsp_flg}, 64'd0);
    chk("rst_tag", {60'd0, rsp_tag}, 64'd0);
    chk("rst_en", {63'd0, f_en}, 64'd0);
    chk("rst_ready", {63'd0, req_r}, 64'd1);
    req_v = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1);

    // single op latency
    send(4'h5, 32'h3F80_0000, 32'h0, 4'h0, 3'h0, w);
    wait_valid(n);
    chk("t1_lat", n, LAT + 1);
    chk("t1_res", {32'd0, rsp_res}, 64'h3F80_0000);
    chk("t1_tag", {60'd0, rsp_tag}, 64'h5);
    @(posedge clk);
    #1;
    rsp_r = 1'b1;
    step(1);
    rsp_r = 1'b0;
    @(negedge clk);
    chk("t1_popped", {63'd0, rsp_v}, 64'd0);
    step(1);

    // back-to-back stream
    rsp_r = 1'b1;
    pop_cyc.delete();
    tw = 0;
    for (int i = 0; i < 8; i++) begin
      send(4'(i), $urandom, $urandom, 4'(i), 3'(i), w);
      tw += w;
    end
    chk("b2b_ready", tw, 0);
    step(6);
    chk("b2b_pops", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8)
      chk("b2b_consec", pop_cyc[7] - pop_cyc[0], 7);
    chk("b2b_drain", sb.size(), 0);

    // backpressure fills exactly DEPTH credits
    rsp_r = 1'b0;
    acc = 0;
    req_v = 1'b1;
    req_tag = 4'h0;
    req_a = $urandom;
    req_b = $urandom;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req_r) acc++;
      @(posedge clk);
      #1;
      req_tag = 4'(acc);
      req_a = $urandom;
    end
    chk("bp_accepts", acc, DEP);
    @(negedge clk);
    chk("bp_ready_lo", {63'd0, req_r}, 64'd0);
    @(posedge clk);
    #1;
    req_v = 1'b0;
    rsp_r = 1'b1;
    @(negedge clk);
    chk("bp_no_path", {63'd0, req_r}, 64'd0);
    @(posedge clk);
    #1;
    rsp_r = 1'b0;
    @(negedge clk);
    chk("bp_ready_back", {63'd0, req_r}, 64'd1);
    @(posedge clk);
    #1;
    rsp_r = 1'b1;
    step(6);
    chk("bp_drain", sb.size(), 0);

    // halt for 3 cycles with 2 in flight
    send(4'hA, 32'hCAFE_0001, 32'h0BAD_F00D, 4'h3, 3'h2, w);
    send(4'hB, 32'hCAFE_0002, 32'h1111_2222, 4'h4, 3'h5, w);
    halt = 1'b1;
    req_v = 1'b1;
    req_tag = 4'hE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("h_stall", {63'd0, f_stall}, 64'd1);
      chk("h_ready", {63'd0, req_r}, 64'd0);
      chk("h_en", {63'd0, f_en}, 64'd0);
      chk("h_nocap", {63'd0, rsp_v}, 64'd0);
      @(posedge clk);
      #1;
    end
    req_v = 1'b0;
    halt = 1'b0;
    wait_valid(n);
    chk("h_lat", n, 2);
    chk("h_tag_a", {60'd0, rsp_tag}, 64'hA);
    @(posedge clk);
    #1;
    step(3);
    chk("h_drain", sb.size(), 0);

    // flush with 2 queued and 2 in flight
    rsp_r = 1'b0;
    for (int i = 0; i < 4; i++)
      send(4'(8 + i), $urandom, $urandom, 4'(i), 3'(i), w);
    @(negedge clk);
    chk("fl_pre_valid", {63'd0, rsp_v}, 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("fl_ready_lo", {63'd0, req_r}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("fl_valid", {63'd0, rsp_v}, 64'd0);
    chk("fl_ready", {63'd0, req_r}, 64'd1);
    rsp_r = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_v) seen++;
    end
    chk("fl_no_ghost", seen, 0);
    @(posedge clk);
    #1;

    // async reset mid-stream
    rsp_r = 1'b0;
    for (int i = 0; i < 3; i++)
      send(4'(3 + i), 32'hFFFF_0000 | 32'(i), 32'h8, 4'h1, 3'h1, w);
    step(2);
    @(negedge clk);
    chk("ar_pre_valid", {63'd0, rsp_v}, 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {63'd0, rsp_v}, 64'd0);
    chk("ar_res", {32'd0, rsp_res}, 64'd0);
    chk("ar_flg", {58'd0, rsp_flg}, 64'd0);
    chk("ar_tag", {60'd0, rsp_tag}, 64'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    rsp_r = 1'b1;
    send(4'hC, 32'h4049_0FDB, 32'h4000_0000, 4'h7, 3'h3, w);
    wait_valid(n);
    chk("ar_lat", n, LAT + 1);
    chk("ar_tag_new", {60'd0, rsp_tag}, 64'hC);
    @(posedge clk);
    #1;
    step(2);
    chk("ar_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
